mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- M stage of the 16-bit CPU in the crypto accelerator; consumes the EX/MEM pipeline register produced by the execute stage.
- Treats the EX/MEM ALU result as a data-memory address (LD/ST) or as a pass-through result (all other ops), and drives a req/ack data-memory bus.
- Stalls upstream stages while an access is outstanding, then loads the MEM/WB register, whose memwb_data also feeds Mem-to-Ex forwarding.

Parameters:
DATA_W, 16, data and address width
TIMEOUT, 15, max cycles in REQ without dmem_ack before bus error (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
exmem_valid  in  1  EX/MEM holds a live instruction
exmem_mem_read  in  1  LD
exmem_mem_write  in  1  ST
exmem_reg_write  in  1  instruction writes the register file
exmem_rd  in  3  destination register
exmem_alu_out  in  DATA_W  address (LD/ST) or ALU result
exmem_value_to_write  in  DATA_W  ST data
stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  DATA_W  word address
dmem_wdata  out  DATA_W  write data
dmem_ack  in  1  responder completes access this cycle
dmem_rdata  in  DATA_W  read data, valid with dmem_ack
memwb_valid  out  1  MEM/WB holds a live instruction
memwb_reg_write  out  1  to WB
memwb_rd  out  3  to WB
memwb_data  out  DATA_W  load data or ALU result; also the Mem-to-Ex forward value
bus_err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE; stall, dmem_req, dmem_we, memwb_valid, memwb_reg_write and bus_err are 0; dmem_addr, dmem_wdata, memwb_rd and memwb_data are 0; timeout counter is 0.
- Memory op: mem_op = exmem_valid & (exmem_mem_read | exmem_mem_write).
- If both exmem_mem_read and exmem_mem_write are set, the access is a write; memwb_data = exmem_alu_out; memwb_reg_write is forced to 0.
- IDLE, no mem_op: stall = 0. Next edge:
  - memwb_valid <= exmem_valid
  - memwb_data <= exmem_alu_out
  - memwb_rd and memwb_reg_write are copied from EX/MEM (qualified by exmem_valid).
- IDLE, mem_op:
  - stall = 1 (combinational).
  - Next edge: latch addr, wdata, we, rd, reg_write, alu_out; memwb_valid <= 0; go to REQ.
- REQ:
  - dmem_req = 1; dmem_addr, dmem_wdata and dmem_we stay stable until ack.
  - stall = ~dmem_ack.
  - On dmem_ack, next edge:
    - memwb_valid <= 1
    - memwb_data <= dmem_rdata for a read, latched alu_out for a write
    - state <= IDLE; counter cleared
    - dmem_req deasserts at that edge.
- Latency: minimum 2 cycles from mem_op presentation to memwb_valid (ack in the first REQ cycle). A non-memory op takes 1 cycle.
- Back-to-back: after the ack edge, IDLE samples the new EX/MEM contents in the same cycle. A second mem_op re-enters REQ after one IDLE cycle. dmem_req is low for exactly one cycle between accesses.
- Timeout:
  - The counter increments each REQ cycle without ack.
  - When counter == TIMEOUT-1 and no ack, next edge:
    - bus_err <= 1
    - memwb_valid <= 1, memwb_reg_write <= 0, memwb_data <= 16'h0000
    - state <= IDLE.
  - stall is 0 in that final cycle.
  - bus_err clears only on rst.
  - An ack arriving in the same cycle as the timeout wins (normal completion).
- dmem_ack while in IDLE: ignored.
- rst mid-access: dmem_req drops immediately (asynchronous). A responder must abandon the access.
- memwb_* outputs are registers only; no combinational path from dmem_rdata to memwb_data.

Optional Feature:
- MEM_STORE_FWD_EN defined:
  - One-entry store buffer {valid, addr, data}, updated on every completed write. Cleared on rst.
  - A read in IDLE whose exmem_alu_out equals the buffered addr while the buffer is valid issues no bus access and raises no stall.
  - Next edge: memwb_data <= buffered data, memwb_valid <= 1 (1-cycle latency).
- Undefined: no buffer; every read goes to the bus.

Test Plan:
- Non-mem ADD: exmem_alu_out=16'h1234, reg_write=1, rd=3 -> next cycle memwb_valid=1, memwb_data=16'h1234, memwb_rd=3, stall never asserted, dmem_req=0.
- ST then LD: ST addr=16'h0040, data=16'hBEEF, ack 3 cycles after req -> stall high 4 cycles, dmem_we=1, addr/wdata stable. LD 16'h0040 with rdata=16'hBEEF and immediate ack -> memwb_data=16'hBEEF two cycles after presentation.
- Timeout: LD with ack never asserted -> dmem_req high exactly 15 cycles, then bus_err=1, memwb_valid=1, memwb_reg_write=0, memwb_data=16'h0000, stall low; bus_err remains 1 until rst.
- Reset mid-access: assert rst in the 2nd REQ cycle -> dmem_req, stall and memwb_valid go to 0 without a clock edge; after rst release, state is IDLE.
- Read+write both set, addr=16'h0010, alu_out=16'h0010 -> bus write performed, memwb_reg_write=0, memwb_data=16'h0010.
- MEM_STORE_FWD_EN: ST 16'h0020<=16'hCAFE then LD 16'h0020 -> no dmem_req for the LD, stall=0, memwb_data=16'hCAFE next cycle. Without the macro: a normal bus read is issued.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: M stage of the 16-bit CPU. It turns EX/MEM into a req/ack
// data-memory access (LD/ST) or a pass-through result. While an access is
// outstanding it stalls the upstream stages. When the access ends it loads MEM/WB.
// Optional feature: define MEM_STORE_FWD_EN to enable a one-entry store buffer.
// A read that hits the buffer completes in one cycle and makes no bus access.
//
// Handshake: dmem_req stays high from the first REQ cycle until the cycle in
// which dmem_ack is sampled high. dmem_addr, dmem_wdata and dmem_we are held
// stable throughout. An access completes on the clock edge where dmem_req and
// dmem_ack are both high. dmem_ack is ignored while dmem_req is low.
module mem_access_unit #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exmem_valid,
  input  logic              exmem_mem_read,
  input  logic              exmem_mem_write,
  input  logic              exmem_reg_write,
  input  logic [2:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_alu_out,
  input  logic [DATA_W-1:0] exmem_value_to_write,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              memwb_valid,
  output logic              memwb_reg_write,
  output logic [2:0]        memwb_rd,
  output logic [DATA_W-1:0] memwb_data,
  output logic              bus_err
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q;
  logic [DATA_W-1:0]   addr_q;   // also the ALU result returned for a store
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic [2:0]          rd_q;
  logic                rw_q;

  logic                mem_op;
  logic                fwd_hit;
  logic [DATA_W-1:0]   fwd_data;
  logic                timeout_hit;

  assign mem_op      = exmem_valid & (exmem_mem_read | exmem_mem_write);
  assign timeout_hit = (state_q == REQ) & ~dmem_ack & (cnt_q == TO_LAST);

`ifdef MEM_STORE_FWD_EN
  logic              sb_valid;
  logic [DATA_W-1:0] sb_addr;
  logic [DATA_W-1:0] sb_data;

  // A pure read of the last stored address is served from the buffer.
  assign fwd_hit  = exmem_valid & exmem_mem_read & ~exmem_mem_write &
                    sb_valid & (exmem_alu_out == sb_addr);
  assign fwd_data = sb_data;

  // Capture every write that the bus acknowledges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid <= 1'b0;
      sb_addr  <= '0;
      sb_data  <= '0;
    end else if ((state_q == REQ) && dmem_ack && we_q) begin
      sb_valid <= 1'b1;
      sb_addr  <= addr_q;
      sb_data  <= wdata_q;
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // Bus outputs come from the latched request. Reset returns to IDLE, so dmem_req drops at once.
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  // Next state and stall: stall while an access is pending, not in the ending cycle.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !fwd_hit) begin
          stall   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall = ~dmem_ack & ~timeout_hit;
        if (dmem_ack || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  // State register, request latches, timeout counter and MEM/WB register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      we_q            <= 1'b0;
      rd_q            <= '0;
      rw_q            <= 1'b0;
      memwb_valid     <= 1'b0;
      memwb_reg_write <= 1'b0;
      memwb_rd        <= '0;
      memwb_data      <= '0;
      bus_err         <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (fwd_hit) begin
            memwb_valid     <= 1'b1;
            memwb_data      <= fwd_data;
            memwb_rd        <= exmem_rd;
            memwb_reg_write <= exmem_reg_write;
          end else if (mem_op) begin
            addr_q      <= exmem_alu_out;
            wdata_q     <= exmem_value_to_write;
            we_q        <= exmem_mem_write;
            rd_q        <= exmem_rd;
            // A store, including read+write, never writes the register file.
            rw_q        <= exmem_reg_write & ~exmem_mem_write;
            cnt_q       <= '0;
            memwb_valid <= 1'b0;
          end else begin
            memwb_valid     <= exmem_valid;
            memwb_data      <= exmem_alu_out;
            memwb_rd        <= exmem_rd;
            memwb_reg_write <= exmem_valid & exmem_reg_write;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            memwb_valid     <= 1'b1;
            memwb_data      <= we_q ? addr_q : dmem_rdata;
            memwb_rd        <= rd_q;
            memwb_reg_write <= rw_q;
            cnt_q           <= '0;
          end else if (cnt_q == TO_LAST) begin
            bus_err         <= 1'b1;
            memwb_valid     <= 1'b1;
            memwb_data      <= '0;
            memwb_rd        <= rd_q;
            memwb_reg_write <= 1'b0;
            cnt_q           <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random instruction stream for mem_access_unit.
// A word-addressed memory model answers the bus. Expectations come from
// per-instruction rules. Rules give stall and request counts, the MEM/WB result
// and the sticky bus error.
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        exmem_valid, exmem_mem_read, exmem_mem_write, exmem_reg_write;
  logic [2:0]  exmem_rd;
  logic [15:0] exmem_alu_out, exmem_value_to_write;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        memwb_valid, memwb_reg_write, bus_err;
  logic [2:0]  memwb_rd;
  logic [15:0] memwb_data;

  mem_access_unit #(.DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .exmem_valid(exmem_valid), .exmem_mem_read(exmem_mem_read),
    .exmem_mem_write(exmem_mem_write), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
    .exmem_value_to_write(exmem_value_to_write),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .memwb_valid(memwb_valid), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_data(memwb_data), .bus_err(bus_err)
  );

  // Clock
  always #5 clk = ~clk;

  int          vectors = 0;
  int          fails   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] ref_mem [logic [15:0]];
  logic        m_err = 1'b0;
`ifdef MEM_STORE_FWD_EN
  logic        sb_v = 1'b0;
  logic [15:0] sb_a = '0;
  logic [15:0] sb_d = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return {a[7:0], ~a[7:0]};
  endfunction

  // Present one instruction, answer the bus after 'delay' REQ cycles, then check MEM/WB.
  task automatic run_op(input logic v, input logic rd_f, input logic wr_f, input logic rw,
                        input logic [2:0] rd, input logic [15:0] alu, input logic [15:0] wval,
                        input int delay);
    logic mem_op, fwd, exp_v, exp_rw, done;
    int   exp_req, exp_stall, n_req, n_stall;
    mem_op = v & (rd_f | wr_f);
`ifdef MEM_STORE_FWD_EN
    fwd = v & rd_f & ~wr_f & sb_v & (sb_a == alu);
`else
    fwd = 1'b0;
`endif
    exp_v = v;
    if (!mem_op) begin
      exp_req = 0; exp_stall = 0; exp_rw = v & rw; exp_q.push_back(alu);
    end else if (fwd) begin
      exp_req = 0; exp_stall = 0; exp_rw = rw; exp_q.push_back(rd_mem(alu));
    end else if (delay >= TIMEOUT) begin
      exp_req = TIMEOUT; exp_stall = TIMEOUT; exp_rw = 1'b0; m_err = 1'b1;
      exp_q.push_back(16'h0000);
    end else begin
      exp_req = delay + 1; exp_stall = delay + 1;
      exp_rw  = wr_f ? 1'b0 : rw;
      exp_q.push_back(wr_f ? alu : rd_mem(alu));
    end

    exmem_valid = v; exmem_mem_read = rd_f; exmem_mem_write = wr_f;
    exmem_reg_write = rw; exmem_rd = rd; exmem_alu_out = alu; exmem_value_to_write = wval;
    n_req = 0; n_stall = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("req_low_first_cycle", 32'(dmem_req), 32'(0));
      if (dmem_req) begin
        chk("dmem_addr", 32'(dmem_addr), 32'(alu));
        chk("dmem_we", 32'(dmem_we), 32'(wr_f));
        if (wr_f) chk("dmem_wdata", 32'(dmem_wdata), 32'(wval));
        if (n_req == delay) begin
          dmem_ack = 1'b1;
          if (wr_f) begin
            ref_mem[alu] = wval;
`ifdef MEM_STORE_FWD_EN
            sb_v = 1'b1; sb_a = alu; sb_d = wval;
`endif
          end else begin
            dmem_rdata = rd_mem(alu);
          end
        end
        n_req++;
      end
      #1;
      if (stall) n_stall++; else done = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = 16'($urandom);
    end
    chk("accepted_in_bound", 32'(done), 32'(1));
    chk("req_cycles", 32'(n_req), 32'(exp_req));
    chk("stall_cycles", 32'(n_stall), 32'(exp_stall));
    chk("memwb_valid", 32'(memwb_valid), 32'(exp_v));
    chk("memwb_data", 32'(memwb_data), 32'(exp_q.pop_front()));
    chk("memwb_reg_write", 32'(memwb_reg_write), 32'(exp_rw));
    if (exp_v) chk("memwb_rd", 32'(memwb_rd), 32'(rd));
    chk("bus_err", 32'(bus_err), 32'(m_err));
    exmem_valid = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    exmem_valid = 1'b0; exmem_mem_read = 1'b0; exmem_mem_write = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_alu_out = '0; exmem_value_to_write = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_dmem_req", 32'(dmem_req), 32'(0));
    chk("rst_dmem_we", 32'(dmem_we), 32'(0));
    chk("rst_dmem_addr", 32'(dmem_addr), 32'(0));
    chk("rst_dmem_wdata", 32'(dmem_wdata), 32'(0));
    chk("rst_memwb_valid", 32'(memwb_valid), 32'(0));
    chk("rst_memwb_reg_write", 32'(memwb_reg_write), 32'(0));
    chk("rst_memwb_rd", 32'(memwb_rd), 32'(0));
    chk("rst_memwb_data", 32'(memwb_data), 32'(0));
    chk("rst_bus_err", 32'(bus_err), 32'(0));
    @(posedge clk); #1; rst = 1'b0;

    // Directed steps
    run_op(1, 0, 0, 1, 3'd3, 16'h1234, 16'h0000, 0);   // ADD pass-through
    run_op(1, 0, 1, 0, 3'd0, 16'h0040, 16'hBEEF, 3);   // ST, ack after 3 wait cycles
    run_op(1, 1, 0, 1, 3'd5, 16'h0040, 16'h0000, 0);   // LD same address
    run_op(1, 1, 1, 1, 3'd2, 16'h0010, 16'h5555, 1);   // read+write -> write
    run_op(1, 0, 1, 0, 3'd0, 16'h0020, 16'hCAFE, 0);   // ST
    run_op(1, 1, 0, 1, 3'd6, 16'h0020, 16'h0000, 1);   // LD of the stored word
    run_op(1, 1, 0, 1, 3'd1, 16'h0030, 16'h0000, TIMEOUT - 1); // ack on the last allowed cycle
    run_op(0, 1, 0, 1, 3'd4, 16'h0077, 16'h0000, 0);   // bubble, ack ignored
    run_op(1, 1, 0, 1, 3'd7, 16'h0050, 16'h0000, 255); // timeout
    run_op(1, 0, 0, 1, 3'd2, 16'hA5A5, 16'h0000, 0);   // bus_err stays set

    // Random stream
    for (int i = 0; i < 30; i++) begin
      int kind;
      logic [15:0] a;
      kind = $urandom_range(0, 4);
      a = 16'($urandom_range(0, 7)) << 2;
      case (kind)
        0: run_op(0, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), a, 16'($urandom), 0);
        1: run_op(1, 0, 0, 1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), 0);
        2: run_op(1, 1, 0, 1'($urandom), 3'($urandom), a, 16'($urandom), $urandom_range(0, 4));
        3: run_op(1, 0, 1, 1'($urandom), 3'($urandom), a, 16'($urandom), $urandom_range(0, 4));
        default: run_op(1, 1, 1, 1'($urandom), 3'($urandom), a, 16'($urandom), $urandom_range(0, 4));
      endcase
    end

    // Reset in the second REQ cycle of a load
    exmem_valid = 1'b1; exmem_mem_read = 1'b1; exmem_mem_write = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 3'd1; exmem_alu_out = 16'h0077;
    repeat (3) @(negedge clk);
    chk("req_before_rst", 32'(dmem_req), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dmem_req", 32'(dmem_req), 32'(0));
    chk("async_rst_stall", 32'(stall), 32'(0));
    chk("async_rst_memwb_valid", 32'(memwb_valid), 32'(0));
    chk("async_rst_bus_err", 32'(bus_err), 32'(0));
    m_err = 1'b0;
`ifdef MEM_STORE_FWD_EN
    sb_v = 1'b0;
`endif
    exmem_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    run_op(1, 0, 0, 1, 3'd3, 16'h0BAD, 16'h0000, 0);   // back in IDLE: 1-cycle pass-through
    run_op(1, 1, 0, 1, 3'd4, 16'h0040, 16'h0000, 2);   // buffer cleared: bus read

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
